// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its frame debouncer.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_EVAL,
    ST_EMIT_REL,
    ST_EMIT_PRESS
  } scan_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } frame_cls_e;

  // Ceiling log2, never below 1 so every derived vector has at least one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Classifies each completed scan frame, counts consecutive identical frames and
// holds the debounced single-key state, requesting release/press events on change.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DEB_FRAMES = 20,
  localparam int N         = ROWS * COLS,
  localparam int KEY_W     = clog2(N)
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             eval_i,
  input  logic [N-1:0]     frame_i,
  output logic             rel_req_o,
  output logic [KEY_W-1:0] rel_code_o,
  output logic             press_req_o,
  output logic [KEY_W-1:0] press_code_o,
  output logic             multi_key_o
);

  localparam int CNT_W = clog2(DEB_FRAMES + 1);

  frame_cls_e       cls;
  logic [KEY_W-1:0] hit_code;
  logic [1:0]       ones;

  frame_cls_e       last_cls_q;
  logic [KEY_W-1:0] last_code_q;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             deb_held_q;
  logic [KEY_W-1:0] deb_code_q;
  logic             multi_q;
  logic             same_cls;
  logic             accept;

  // NOTE: every variable assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ones     = 2'd0;
    hit_code = '0;
    for (int i = 0; i < N; i++) begin
      if (frame_i[i]) begin
        if (ones != 2'd2) ones = ones + 2'd1;
        hit_code = KEY_W'(i);
      end
    end
    case (ones)
      2'd0:    cls = CLS_NONE;
      2'd1:    cls = CLS_SINGLE;
      default: cls = CLS_MULTI;
    endcase
  end

  always_comb begin
    same_cls = (cls == last_cls_q) && ((cls != CLS_SINGLE) || (hit_code == last_code_q));
    if (!same_cls)                              stab_cnt_d = CNT_W'(1);
    else if (stab_cnt_q == CNT_W'(DEB_FRAMES))  stab_cnt_d = stab_cnt_q;
    else                                        stab_cnt_d = stab_cnt_q + CNT_W'(1);

    // A MULTI frame is never accepted, so the debounced state only moves between NONE and SINGLE.
    accept = eval_i && (stab_cnt_d == CNT_W'(DEB_FRAMES)) && (cls != CLS_MULTI) &&
             (((cls == CLS_SINGLE) != deb_held_q) ||
              ((cls == CLS_SINGLE) && (hit_code != deb_code_q)));
  end

  assign rel_req_o    = accept && deb_held_q;
  assign rel_code_o   = deb_code_q;
  assign press_req_o  = accept && (cls == CLS_SINGLE);
  assign press_code_o = hit_code;
  assign multi_key_o  = multi_q;

  // NOTE: sequential state is written with non-blocking assignments only, so all
  // registers update together at the clock edge regardless of statement order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cls_q  <= CLS_NONE;
      last_code_q <= '0;
      stab_cnt_q  <= '0;
      deb_held_q  <= 1'b0;
      deb_code_q  <= '0;
      multi_q     <= 1'b0;
    end else if (eval_i) begin
      last_cls_q  <= cls;
      last_code_q <= hit_code;
      stab_cnt_q  <= stab_cnt_d;
      multi_q     <= (cls == CLS_MULTI);
      if (accept) begin
        deb_held_q <= (cls == CLS_SINGLE);
        deb_code_q <= hit_code;
      end
    end
  end

endmodule

// File: rtl/matrix_keypad_scan.sv
// Matrix keypad scanner: walks an active-low column, samples synchronised rows into
// a frame, and emits debounced press/release events through a small event FSM.
module matrix_keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DWELL_CYC  = 50000,
  parameter int DEB_FRAMES = 20,
  localparam int KEY_W     = clog2(ROWS * COLS)
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic             key_valid,
  output logic             key_press,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held,
  output logic             multi_key
);

  localparam int N     = ROWS * COLS;
  localparam int DW_W  = clog2(DWELL_CYC);
  localparam int COL_W = clog2(COLS);

  logic [ROWS-1:0]  row_meta_q, row_sync_q;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [COLS-1:0]  col_n_q, col_n_d;
  logic [N-1:0]     frame_q, frame_d;
  logic             dwell_last, frame_end;

  scan_state_e      state_q, state_d;
  logic             pend_press_q, pend_press_d;
  logic [KEY_W-1:0] pend_code_q, pend_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_press_q, key_press_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_held_q, key_held_d;

  logic             rel_req, press_req;
  logic [KEY_W-1:0] rel_code, press_code;

  assign dwell_last = (dwell_q == DW_W'(DWELL_CYC - 1));
  assign frame_end  = dwell_last && (col_q == COL_W'(COLS - 1));

  always_comb begin
    dwell_d = dwell_last ? '0 : dwell_q + DW_W'(1);
    col_d   = col_q;
    if (dwell_last) col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
    for (int c = 0; c < COLS; c++) col_n_d[c] = (col_d != COL_W'(c));

    // Row bits are captured on the last dwell cycle, giving the synchroniser time to settle.
    frame_d = frame_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (dwell_last && (col_q == COL_W'(c))) frame_d[r*COLS + c] = ~row_sync_q[r];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      dwell_q    <= '0;
      col_q      <= '0;
      col_n_q    <= '1;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_n_q    <= col_n_d;
    end
  end

  // NOTE: the frame buffer has no reset; every bit is rewritten during the first
  // full scan, before the first evaluation ever reads it.
  always_ff @(posedge sys_clk) begin
    frame_q <= frame_d;
  end

  keypad_frame_debounce #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DEB_FRAMES (DEB_FRAMES)
  ) u_debounce (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .eval_i       (state_q == ST_EVAL),
    .frame_i      (frame_q),
    .rel_req_o    (rel_req),
    .rel_code_o   (rel_code),
    .press_req_o  (press_req),
    .press_code_o (press_code),
    .multi_key_o  (multi_key)
  );

  always_comb begin
    state_d      = state_q;
    pend_press_d = pend_press_q;
    pend_code_d  = pend_code_q;
    key_valid_d  = 1'b0;
    key_press_d  = key_press_q;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;

    unique case (state_q)
      ST_SCAN: begin
        if (frame_end) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        pend_press_d = press_req;
        pend_code_d  = press_code;
        if (rel_req) begin
          state_d     = ST_EMIT_REL;
          key_valid_d = 1'b1;
          key_press_d = 1'b0;
          key_code_d  = rel_code;
          key_held_d  = 1'b0;
        end else if (press_req) begin
          state_d     = ST_EMIT_PRESS;
          key_valid_d = 1'b1;
          key_press_d = 1'b1;
          key_code_d  = press_code;
          key_held_d  = 1'b1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_EMIT_REL: begin
        // A key-to-key change queues its press right behind the release.
        if (pend_press_q) begin
          state_d     = ST_EMIT_PRESS;
          key_valid_d = 1'b1;
          key_press_d = 1'b1;
          key_code_d  = pend_code_q;
          key_held_d  = 1'b1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_EMIT_PRESS: begin
        state_d = ST_SCAN;
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SCAN;
      pend_press_q <= 1'b0;
      pend_code_q  <= '0;
      key_valid_q  <= 1'b0;
      key_press_q  <= 1'b0;
      key_code_q   <= '0;
      key_held_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_press_q <= pend_press_d;
      pend_code_q  <= pend_code_d;
      key_valid_q  <= key_valid_d;
      key_press_q  <= key_press_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_valid = key_valid_q;
  assign key_press = key_press_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// Directed bench for matrix_keypad_scan (4x4, 4-cycle dwell, 3-frame debounce) with a
// switch-matrix model driving row_n from col_n and the set of keys held down.
module tb_matrix_keypad_scan;

  logic       sys_clk;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic       key_press;
  logic [3:0] key_code;
  logic       key_held;
  logic       multi_key;

  logic [15:0] keys;
  int          checks;
  int          failures;
  int          cyc;

  typedef struct {
    logic       press;
    logic [3:0] code;
    logic       held;
    int         at;
  } ev_t;

  ev_t evq[$];

  matrix_keypad_scan #(
    .ROWS       (4),
    .COLS       (4),
    .DWELL_CYC  (4),
    .DEB_FRAMES (3)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_press (key_press),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // A held key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds the given key set for n whole frames, checking the column walk every cycle
  // and logging every event strobe with its cycle number since reset release.
  task automatic run_frames(input logic [15:0] k, input int n);
    logic [3:0] one;
    logic [3:0] exp_col;
    ev_t        e;
    one  = 4'b0001;
    keys = k;
    repeat (n * 16) begin
      @(posedge sys_clk);
      #1;
      cyc++;
      exp_col = ~(one << ((cyc / 4) % 4));
      check("col_n", 32'(col_n), 32'(exp_col));
      if (key_valid) begin
        e.press = key_press;
        e.code  = key_code;
        e.held  = key_held;
        e.at    = cyc;
        evq.push_back(e);
      end
    end
  endtask

  task automatic check_ev(input int idx, input logic press, input logic [3:0] code, input int at);
    check($sformatf("ev%0d_present", idx), 32'(evq.size() > idx), 32'd1);
    if (evq.size() > idx) begin
      check($sformatf("ev%0d_press", idx), 32'(evq[idx].press), 32'(press));
      check($sformatf("ev%0d_code", idx), 32'(evq[idx].code), 32'(code));
      check($sformatf("ev%0d_held", idx), 32'(evq[idx].held), 32'(press));
      check($sformatf("ev%0d_cycle", idx), 32'(evq[idx].at), 32'(at));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    keys     = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_col_n", 32'(col_n), 32'hF);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_press", 32'(key_press), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_multi_key", 32'(multi_key), 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Idle: frames 1-10, no keys
    run_frames(16'h0000, 10);
    check("idle_events", 32'(evq.size()), 32'd0);

    // Key 9 (row 2, col 1): frames 11-15 held, 16-20 released
    run_frames(16'h0200, 5);
    check("k9_events", 32'(evq.size()), 32'd1);
    check_ev(0, 1'b1, 4'd9, 209);
    check("k9_held", 32'(key_held), 32'd1);
    run_frames(16'h0000, 5);
    check("k9_rel_events", 32'(evq.size()), 32'd2);
    check_ev(1, 1'b0, 4'd9, 289);
    check("k9_rel_held", 32'(key_held), 32'd0);

    // Bouncing key 0 for frames 21-26, then stable 27-30, released 31-34
    for (int f = 0; f < 6; f++) run_frames((f % 2 == 0) ? 16'h0001 : 16'h0000, 1);
    check("bounce_events", 32'(evq.size()), 32'd2);
    run_frames(16'h0001, 4);
    check_ev(2, 1'b1, 4'd0, 465);
    run_frames(16'h0000, 4);
    check_ev(3, 1'b0, 4'd0, 529);

    // Direct change 5 -> 14: frames 35-38 key 5, 39-42 key 14, 43-46 none
    run_frames(16'h0020, 4);
    check_ev(4, 1'b1, 4'd5, 593);
    run_frames(16'h4000, 4);
    check_ev(5, 1'b0, 4'd5, 657);
    check_ev(6, 1'b1, 4'd14, 658);
    check("k14_held", 32'(key_held), 32'd1);
    run_frames(16'h0000, 4);
    check_ev(7, 1'b0, 4'd14, 721);

    // Keys 3 and 12 together for frames 47-51, then key 3 alone for 52-55
    run_frames(16'h1008, 5);
    check("multi_set", 32'(multi_key), 32'd1);
    check("multi_events", 32'(evq.size()), 32'd8);
    check("multi_held", 32'(key_held), 32'd0);
    run_frames(16'h0008, 2);
    check("multi_clear", 32'(multi_key), 32'd0);
    check("multi_drop_events", 32'(evq.size()), 32'd8);
    run_frames(16'h0008, 2);
    check_ev(8, 1'b1, 4'd3, 865);
    run_frames(16'h0000, 4);
    check_ev(9, 1'b0, 4'd3, 929);
    check("total_events", 32'(evq.size()), 32'd10);

    // Key 7 held through frames 60-63, then reset while it is debounced
    run_frames(16'h0080, 4);
    check_ev(10, 1'b1, 4'd7, 993);
    check("k7_held", 32'(key_held), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_key_held", 32'(key_held), 32'd0);
    check("midrst_col_n", 32'(col_n), 32'hF);
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    keys = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("midrst_col_n_hold", 32'(col_n), 32'hF);
    @(negedge sys_clk);
    rst_n = 1'b1;
    cyc   = 0;
    evq.delete();
    run_frames(16'h0080, 4);
    check("repress_events", 32'(evq.size()), 32'd1);
    check_ev(0, 1'b1, 4'd7, 49);
    check("repress_held", 32'(key_held), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
